// File: rtl/stream_chk_pkg.sv
// Shared types and defaults for the 16-bit read-back stream checker.
package stream_chk_pkg;

  localparam int unsigned WORD_W_DEF   = 16;
  localparam int unsigned CNT_W_DEF    = 32;
  localparam int unsigned LOSS_THR_DEF = 4;

  // Low half of each 32-bit counter word arrives first on the stream.
  localparam bit LO_FIRST = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SEED_LO,
    SEED_HI,
    CHK_LO,
    CHK_HI
  } chk_state_e;

endpackage

// File: rtl/s16_stream_checker_if.sv
// Tap of the SDRAM read-back stream: one 16-bit word plus its valid strobe.
interface s16_stream_checker_if
  import stream_chk_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF
) ();

  logic [WORD_W-1:0] s16;
  logic              s16_vld;

  modport master (output s16, output s16_vld);
  modport slave  (input  s16, input  s16_vld);

endinterface

// File: rtl/sat_counter.sv
// Counter that saturates at all-ones; clr restarts it, counting a coincident inc.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/s16_stream_checker.sv
// Passive continuity checker for the 32-bit incrementing counter carried as
// 16-bit halves on the SDRAM read-back stream; never touches the data path.
module s16_stream_checker
  import stream_chk_pkg::*;
#(
  parameter int unsigned WORD_W   = WORD_W_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned LOSS_THR = LOSS_THR_DEF
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  en,
  input  logic                  clr,
  s16_stream_checker_if.slave   s_if,
  output logic                  locked,
  output logic                  err_pulse,
  output logic                  sticky_err,
  output logic [CNT_W-1:0]      word_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  first_err_vld,
  output logic [2*WORD_W-1:0]   first_err_exp,
  output logic [2*WORD_W-1:0]   first_err_got
);

  localparam int unsigned GOT_W = 2 * WORD_W;
  localparam int unsigned RUN_W = $clog2(LOSS_THR + 1);

  chk_state_e        state;
  logic [WORD_W-1:0] lo_reg;
  logic [GOT_W-1:0]  exp_reg;
  logic [RUN_W-1:0]  bad_run;

  logic [GOT_W-1:0]  got_c;
  logic [RUN_W-1:0]  run_nxt_c;
  logic              eval_c;
  logic              mismatch_c;

  assign got_c      = LO_FIRST ? {s_if.s16, lo_reg} : {lo_reg, s_if.s16};
  assign run_nxt_c  = bad_run + RUN_W'(1);
  assign eval_c     = en && s_if.s16_vld && (state == CHK_HI);
  assign mismatch_c = (got_c != exp_reg);

  // Later assignments in this block deliberately override the clr zeroing,
  // so a word evaluated in the clr cycle lands on top of cleared stats.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      lo_reg        <= '0;
      exp_reg       <= '0;
      bad_run       <= '0;
      locked        <= 1'b0;
      err_pulse     <= 1'b0;
      sticky_err    <= 1'b0;
      first_err_vld <= 1'b0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (clr) begin
        sticky_err    <= 1'b0;
        first_err_vld <= 1'b0;
        first_err_exp <= '0;
        first_err_got <= '0;
      end
      if (!en) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= SEED_LO;
          SEED_LO: begin
            if (s_if.s16_vld) begin
              lo_reg <= s_if.s16;
              state  <= SEED_HI;
            end
          end
          SEED_HI: begin
            if (s_if.s16_vld) begin
              exp_reg <= got_c + GOT_W'(1);
              bad_run <= '0;
              locked  <= 1'b1;
              state   <= CHK_LO;
            end
          end
          CHK_LO: begin
            if (s_if.s16_vld) begin
              lo_reg <= s_if.s16;
              state  <= CHK_HI;
            end
          end
          CHK_HI: begin
            if (s_if.s16_vld) begin
              // Resync to the received value so a dropped word costs one error.
              exp_reg <= got_c + GOT_W'(1);
              state   <= CHK_LO;
              if (mismatch_c) begin
                err_pulse  <= 1'b1;
                sticky_err <= 1'b1;
                if (!first_err_vld || clr) begin
                  first_err_vld <= 1'b1;
                  first_err_exp <= exp_reg;
                  first_err_got <= got_c;
                end
                if (run_nxt_c >= RUN_W'(LOSS_THR)) begin
                  bad_run <= '0;
                  locked  <= 1'b0;
                  state   <= SEED_LO;
                end else begin
                  bad_run <= run_nxt_c;
                end
              end else begin
                bad_run <= '0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_word_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (eval_c),
    .clr   (clr),
    .cnt   (word_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (eval_c && mismatch_c),
    .clr   (clr),
    .cnt   (err_cnt)
  );

endmodule

// File: tb/tb_s16_stream_checker.sv
// Self-checking bench: hand-built vector table, randomized stream against a
// word-level reference model, and directed en/clr/reset corner sequences.
module tb_s16_stream_checker;
  import stream_chk_pkg::*;

  localparam int unsigned CNT_W = 32;

  logic              clk;
  logic              n_rst;
  logic              en;
  logic              clr;
  logic              locked;
  logic              err_pulse;
  logic              sticky_err;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic              first_err_vld;
  logic [31:0]       first_err_exp;
  logic [31:0]       first_err_got;

  s16_stream_checker_if #(.WORD_W(16)) sif ();

  s16_stream_checker #(.WORD_W(16), .CNT_W(CNT_W), .LOSS_THR(4)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .en            (en),
    .clr           (clr),
    .s_if          (sif),
    .locked        (locked),
    .err_pulse     (err_pulse),
    .sticky_err    (sticky_err),
    .word_cnt      (word_cnt),
    .err_cnt       (err_cnt),
    .first_err_vld (first_err_vld),
    .first_err_exp (first_err_exp),
    .first_err_got (first_err_got)
  );

  int n_checks;
  int n_fail;

  // Reference model state, updated once per whole 32-bit word.
  bit          m_locked;
  bit          m_pulse;
  bit          m_sticky;
  bit          m_fe_vld;
  logic [31:0] m_exp;
  logic [31:0] m_wc;
  logic [31:0] m_ec;
  logic [31:0] m_fe_exp;
  logic [31:0] m_fe_got;
  int          m_bad;

  typedef struct {
    logic [31:0] word;
    bit          reseed;
    bit          clr;
    bit          pulse;
    bit          lck;
    logic [31:0] wc;
    logic [31:0] ec;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_half(input logic [15:0] h, input int gap);
    sif.s16_vld = 1'b0;
    for (int g = 0; g < gap; g++) begin
      sif.s16 = 16'($urandom);
      tick();
    end
    sif.s16     = h;
    sif.s16_vld = 1'b1;
    tick();
    sif.s16_vld = 1'b0;
    sif.s16     = 16'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_lo, input int gap_hi);
    send_half(w[15:0], gap_lo);
    send_half(w[31:16], gap_hi);
  endtask

  // Word that arrives while hi half coincides with a clr pulse.
  task automatic send_word_clr(input logic [31:0] w);
    send_half(w[15:0], 0);
    sif.s16     = w[31:16];
    sif.s16_vld = 1'b1;
    clr         = 1'b1;
    tick();
    clr         = 1'b0;
    sif.s16_vld = 1'b0;
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_pulse = 1'b0; m_sticky = 1'b0; m_fe_vld = 1'b0;
    m_exp = '0; m_wc = '0; m_ec = '0; m_fe_exp = '0; m_fe_got = '0; m_bad = 0;
  endtask

  task automatic model_clr();
    m_wc = '0; m_ec = '0; m_sticky = 1'b0; m_fe_vld = 1'b0; m_fe_exp = '0; m_fe_got = '0;
  endtask

  task automatic model_word(input logic [31:0] w);
    m_pulse = 1'b0;
    if (!m_locked) begin
      m_locked = 1'b1;
      m_exp    = w + 32'd1;
      m_bad    = 0;
    end else begin
      if (m_wc != 32'hFFFF_FFFF) m_wc = m_wc + 32'd1;
      if (w != m_exp) begin
        m_pulse  = 1'b1;
        m_sticky = 1'b1;
        if (m_ec != 32'hFFFF_FFFF) m_ec = m_ec + 32'd1;
        if (!m_fe_vld) begin
          m_fe_vld = 1'b1; m_fe_exp = m_exp; m_fe_got = w;
        end
        m_bad = m_bad + 1;
      end else begin
        m_bad = 0;
      end
      m_exp = w + 32'd1;
      if (m_bad >= 4) begin
        m_locked = 1'b0;
        m_bad    = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".locked"},    64'(locked),        64'(m_locked));
    check({tag, ".err_pulse"}, 64'(err_pulse),     64'(m_pulse));
    check({tag, ".word_cnt"},  64'(word_cnt),      64'(m_wc));
    check({tag, ".err_cnt"},   64'(err_cnt),       64'(m_ec));
    check({tag, ".sticky"},    64'(sticky_err),    64'(m_sticky));
    check({tag, ".fe_vld"},    64'(first_err_vld), 64'(m_fe_vld));
    check({tag, ".fe_exp"},    64'(first_err_exp), 64'(m_fe_exp));
    check({tag, ".fe_got"},    64'(first_err_got), 64'(m_fe_got));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".locked"},    64'(locked),        64'd0);
    check({tag, ".err_pulse"}, 64'(err_pulse),     64'd0);
    check({tag, ".sticky"},    64'(sticky_err),    64'd0);
    check({tag, ".word_cnt"},  64'(word_cnt),      64'd0);
    check({tag, ".err_cnt"},   64'(err_cnt),       64'd0);
    check({tag, ".fe_vld"},    64'(first_err_vld), 64'd0);
    check({tag, ".fe_exp"},    64'(first_err_exp), 64'd0);
    check({tag, ".fe_got"},    64'(first_err_got), 64'd0);
  endtask

  task automatic en_on();
    en = 1'b1;
    tick();
  endtask

  task automatic en_off();
    en = 1'b0;
    tick();
    m_locked = 1'b0;
  endtask

  function automatic void add(input logic [31:0] w, input bit rs, input bit cl,
                              input bit p, input bit l, input int wc, input int ec);
    vec_t v;
    v.word = w; v.reseed = rs; v.clr = cl; v.pulse = p; v.lck = l;
    v.wc = 32'(wc); v.ec = 32'(ec);
    tbl.push_back(v);
  endfunction

  initial begin
    logic [31:0] seed;
    logic [31:0] w;
    n_checks = 0;
    n_fail   = 0;
    clk = 1'b0; en = 1'b0; clr = 1'b0; n_rst = 1'b0;
    sif.s16 = '0; sif.s16_vld = 1'b0;
    model_reset();

    // Incrementing run, single-word drop, 32-bit wrap, then loss of lock.
    add(32'h10, 1, 0, 0, 1, 0, 0);
    for (int i = 1; i < 10; i++) add(32'(32'h10 + i), 0, 0, 0, 1, i, 0);
    add(32'h100, 1, 1, 0, 1, 0, 0);
    add(32'h101, 0, 0, 0, 1, 1, 0);
    add(32'h103, 0, 0, 1, 1, 2, 1);
    add(32'h104, 0, 0, 0, 1, 3, 1);
    add(32'hFFFF_FFFE, 1, 1, 0, 1, 0, 0);
    add(32'hFFFF_FFFF, 0, 0, 0, 1, 1, 0);
    add(32'h0000_0000, 0, 0, 0, 1, 2, 0);
    add(32'h0000_0001, 0, 0, 0, 1, 3, 0);
    add(32'hDEAD_0000, 0, 0, 1, 1, 4, 1);
    add(32'h1234_5678, 0, 0, 1, 1, 5, 2);
    add(32'h0000_0000, 0, 0, 1, 1, 6, 3);
    add(32'h5555_5555, 0, 0, 1, 0, 7, 4);
    add(32'h0000_0200, 0, 0, 0, 1, 7, 4);
    add(32'h0000_0201, 0, 0, 0, 1, 8, 4);

    #3;
    check_all_zero("reset");
    tick();
    n_rst = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].reseed) begin
        en = 1'b0; tick();
        en = 1'b1; tick();
      end
      if (tbl[i].clr) begin
        clr = 1'b1; tick(); clr = 1'b0;
      end
      send_word(tbl[i].word, i % 3, (i * 5) % 4);
      check($sformatf("vec%0d.err_pulse", i), 64'(err_pulse), 64'(tbl[i].pulse));
      check($sformatf("vec%0d.locked", i),    64'(locked),    64'(tbl[i].lck));
      check($sformatf("vec%0d.word_cnt", i),  64'(word_cnt),  64'(tbl[i].wc));
      check($sformatf("vec%0d.err_cnt", i),   64'(err_cnt),   64'(tbl[i].ec));
      if (i == 12) begin
        check("vec12.fe_exp", 64'(first_err_exp), 64'h102);
        check("vec12.fe_got", 64'(first_err_got), 64'h103);
      end
    end
    check("tbl.fe_vld", 64'(first_err_vld), 64'd1);
    check("tbl.fe_exp", 64'(first_err_exp), 64'h2);
    check("tbl.fe_got", 64'(first_err_got), 64'hDEAD_0000);
    check("tbl.sticky", 64'(sticky_err),     64'd1);

    // Clean random-gap stream of 1000 pairs.
    n_rst = 1'b0; #1; n_rst = 1'b1;
    en = 1'b0; tick();
    model_reset();
    en_on();
    seed = $urandom;
    for (int i = 0; i < 1000; i++) begin
      w = seed + 32'(i);
      send_word(w, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      model_word(w);
      check_model($sformatf("clean%0d", i));
    end
    check("clean.word_cnt_999", 64'(word_cnt), 64'd999);
    check("clean.err_cnt_0",    64'(err_cnt),  64'd0);

    // Stream with sporadic corruption and a mid-stream clr.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        clr = 1'b1; tick(); clr = 1'b0;
        model_clr();
        check_model("clr_mid");
        check("clr_mid.locked_stays", 64'(locked), 64'd1);
      end
      if (!m_locked || $urandom_range(0, 99) < 6) w = $urandom;
      else w = m_exp;
      send_word(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      model_word(w);
      check_model($sformatf("rnd%0d", i));
    end
    if (!m_locked) begin
      w = $urandom;
      send_word(w, 0, 0);
      model_word(w);
    end

    // en dropped between halves: partial pair lost, stats held, clean reseed.
    send_half(16'hABCD, 1);
    en_off();
    check_model("en_off");
    en_on();
    send_word(32'h5000, 2, 0);
    model_word(32'h5000);
    check_model("reseed_a");
    send_word(32'h5001, 0, 3);
    model_word(32'h5001);
    check_model("reseed_b");

    // clr in the same cycle as an evaluated hi half.
    send_word_clr(32'h5002);
    model_clr();
    model_word(32'h5002);
    check_model("clr_eval_ok");
    check("clr_eval_ok.wc1", 64'(word_cnt), 64'd1);
    send_word_clr(32'h9999_0000);
    model_clr();
    model_word(32'h9999_0000);
    check_model("clr_eval_bad");
    check("clr_eval_bad.ec1", 64'(err_cnt), 64'd1);

    // Asynchronous reset between halves clears everything at once.
    send_half(16'h1111, 0);
    n_rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    n_rst = 1'b1;
    model_reset();
    tick();
    send_word(32'h7000, 0, 0);
    model_word(32'h7000);
    check_model("post_rst_seed");
    send_word(32'h7001, 1, 1);
    model_word(32'h7001);
    check_model("post_rst_chk");
    check("post_rst.wc1", 64'(word_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
